uart_rx_frame_chk: RTL and testbench

Parametrised UART receive frame checker, successor to the single-bit start checker. It owns its own oversampling edge/bit counters, samples each bit with majority vote, and validates the whole frame: start glitch, optional parity and stop bit. It sits between the RX line synchroniser and the RX data register and replaces separate start, parity and stop check blocks with one sequential unit.

---
 rtl/uart_rx_pkg.sv | 9 +
 rtl/uart_rx_sampler.sv | 51 +++++
 rtl/uart_rx_frame_chk.sv | 113 +++++++++++
 tb/tb_uart_rx_frame_chk.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM states, parity types and line-level constants shared by the UART RX frame checker
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} par_typ_e;
    localparam logic START_BIT    = 1'b0;
    localparam logic STOP_BIT     = 1'b1;
    localparam logic IDLE_LVL     = 1'b1;
    localparam int   MIN_PRESCALE = 4;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversample edge counter and mid-bit sampler; define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  clr,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] p,
    output logic                  bit_rdy,
    output logic                  bit_done,
    output logic                  bit_val
);
    logic [PRESCALE_W-1:0] edge_cnt, half;
    logic                  s_mid, bit_q, bit_now;

    assign half     = p >> 1;
    assign bit_rdy  = tick && edge_cnt == half + PRESCALE_W'(1);
    assign bit_done = tick && edge_cnt == p - PRESCALE_W'(1);
    // the resolved value is usable on its own resolution tick, which matters when it is also the bit end (P=4)
    assign bit_val  = bit_rdy ? bit_now : bit_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s_lo;
    assign bit_now = (s_lo & s_mid) | (s_lo & rx_in) | (s_mid & rx_in);
    // early sample, one oversample before mid-bit
    always_ff @(posedge clk) begin
        if (rst) s_lo <= IDLE_LVL;
        else if (tick && edge_cnt == half - PRESCALE_W'(1)) s_lo <= rx_in;
    end
`else
    assign bit_now = s_mid;
`endif

    // edge counter wraps at bit end; clr realigns it when the stop bit resolves early
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            s_mid    <= IDLE_LVL;
            bit_q    <= IDLE_LVL;
        end else begin
            if (clr || bit_done) edge_cnt <= '0;
            else if (tick) edge_cnt <= edge_cnt + PRESCALE_W'(1);
            if (tick && edge_cnt == half) s_mid <= rx_in;
            if (bit_rdy) bit_q <= bit_now;
        end
    end
endmodule

// File: rtl/uart_rx_frame_chk.sv
// uart_rx_frame_chk: UART RX frame FSM with start-glitch, parity and stop checks; UART_RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting
module uart_rx_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  os_tick,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);
    rx_state_e             state;
    par_typ_e              par_typ_q;
    logic [PRESCALE_W-1:0] p_lat;
    logic [DATA_W-1:0]     shreg;
    logic [3:0]            bit_cnt;
    logic                  par_en_q, par_bad;
    logic                  tick, clr, bit_rdy, bit_done, bit_val, stop_ok;

    // the start tick counts as edge 0; BREAK and plain IDLE do not count
    assign tick    = os_tick && state != BREAK && (state != IDLE || rx_in == START_BIT);
    assign clr     = state == STOP && bit_rdy;
    assign stop_ok = bit_val == STOP_BIT;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .clr      (clr),
        .rx_in    (rx_in),
        .p        (p_lat),
        .bit_rdy  (bit_rdy),
        .bit_done (bit_done),
        .bit_val  (bit_val)
    );

    // frame FSM: state moves only on os_tick, status pulses clear every clk
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            p_lat       <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= EVEN;
            par_bad     <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            if (os_tick)
                case (state)
                    IDLE: if (rx_in == START_BIT) begin
                        state     <= START;
                        busy      <= 1'b1;
                        p_lat     <= prescale < PRESCALE_W'(MIN_PRESCALE) ? PRESCALE_W'(MIN_PRESCALE) : prescale;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ_e'(par_typ);
                        par_bad   <= 1'b0;
                    end
                    START: if (bit_done) begin
                        if (bit_val != START_BIT) begin
                            strt_glitch <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: if (bit_done) begin
                        shreg   <= {bit_val, shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_W - 1)) state <= par_en_q ? PARITY : STOP;
                    end
                    PARITY: if (bit_done) begin
                        par_bad <= bit_val != (^shreg ^ (par_typ_q == ODD));
                        state   <= STOP;
                    end
                    STOP: if (bit_rdy) begin
                        par_err    <= par_bad;
                        stop_err   <= !stop_ok;
                        data_valid <= !par_bad && stop_ok;
                        if (!par_bad && stop_ok) data_out <= shreg;
                        state      <= stop_ok ? IDLE : BREAK;
                        busy       <= !stop_ok;
                    end
                    BREAK: if (rx_in == IDLE_LVL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb_uart_rx_frame_chk: table-driven, hand-written and randomized frames checked against a waveform-level model
module tb_uart_rx_frame_chk;
    import uart_rx_pkg::*;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0, rst = 1'b1, os_tick = 1'b0, rx_in = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          par_en = 1'b0, par_typ = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid, strt_glitch, par_err, stop_err, busy;

    uart_rx_frame_chk #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .os_tick     (os_tick),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stop_err    (stop_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int n_v = 0, n_g = 0, n_pe = 0, n_se = 0, width_err = 0, pulse_tick = -1, tick_no = 0;
    int b_v, b_g, b_pe, b_se;
    logic pv = 1'b0, pg = 1'b0, pp = 1'b0, ps = 1'b0;
    logic wave[$];

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (data_valid) n_v++;
        if (strt_glitch) n_g++;
        if (par_err) n_pe++;
        if (stop_err) n_se++;
        if ((data_valid && pv) || (strt_glitch && pg) || (par_err && pp) || (stop_err && ps)) width_err++;
        if (data_valid || strt_glitch || par_err || stop_err) pulse_tick = tick_no;
        pv = data_valid; pg = strt_glitch; pp = par_err; ps = stop_err;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_v = n_v; b_g = n_g; b_pe = n_pe; b_se = n_se;
    endtask

    task automatic tick(input logic v);
        rx_in = v; os_tick = 1'b1;
        @(posedge clk); #1;
        os_tick = 1'b0; tick_no++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1);
    endtask

    // inputs are scrambled after the start tick: they must already be latched
    task automatic play(input int n);
        tick_no = 0;
        for (int i = 0; i < n; i++) begin
            tick(wave[i]);
            if (i == 0) begin
                prescale = PW'($urandom);
                par_en   = 1'($urandom);
                par_typ  = 1'($urandom);
            end
        end
    endtask

    task automatic build(input int p, input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        wave.delete();
        for (int t = 0; t < p; t++) wave.push_back(START_BIT);
        for (int j = 0; j < DW; j++) for (int t = 0; t < p; t++) wave.push_back(d[j]);
        if (pe) for (int t = 0; t < p; t++) wave.push_back(pb);
        for (int t = 0; t < p; t++) wave.push_back(sb);
    endtask

    // reference view of a bit: what the line shows around its middle
    function automatic logic res(input int k, input int p);
        int b;
        b = k * p + p / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
        return (wave[b-1] & wave[b]) | (wave[b-1] & wave[b+1]) | (wave[b] & wave[b+1]);
`else
        return wave[b];
`endif
    endfunction

    typedef struct {
        int pre; logic [7:0] d; logic pe, pt, pb, sb;
        logic ev, ep, es; logic [7:0] ed;
    } vec_t;
    vec_t tbl[8];

    int pre, p, j;
    logic [7:0] d, ed, m_data;
    logic pe, pt, pb, sb, ep, es, ev;

    initial begin
        tbl[0] = '{8,  8'hA5, 0, 0, 0, 1, 1, 0, 0, 8'hA5};
        tbl[1] = '{16, 8'h3C, 1, 0, 1, 1, 0, 1, 0, 8'hA5};
        tbl[2] = '{16, 8'h81, 0, 0, 0, 0, 0, 0, 1, 8'hA5};
        tbl[3] = '{5,  8'h12, 1, 1, 1, 1, 1, 0, 0, 8'h12};
        tbl[4] = '{2,  8'h7E, 0, 0, 0, 1, 1, 0, 0, 8'h7E};
        tbl[5] = '{63, 8'hFF, 1, 0, 0, 1, 1, 0, 0, 8'hFF};
        tbl[6] = '{8,  8'h01, 1, 0, 0, 0, 0, 1, 1, 8'hFF};
        tbl[7] = '{4,  8'h00, 1, 1, 0, 1, 0, 1, 0, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_pulses", {28'd0, data_valid, strt_glitch, par_err, stop_err}, 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        idle(3);
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            p = tbl[i].pre < 4 ? 4 : tbl[i].pre;
            prescale = PW'(tbl[i].pre); par_en = tbl[i].pe; par_typ = tbl[i].pt;
            build(p, tbl[i].d, tbl[i].pe, tbl[i].pb, tbl[i].sb);
            snap();
            play(wave.size());
            idle(3);
            chk($sformatf("v%0d_valid", i), 32'(n_v - b_v), 32'(tbl[i].ev));
            chk($sformatf("v%0d_par_err", i), 32'(n_pe - b_pe), 32'(tbl[i].ep));
            chk($sformatf("v%0d_stop_err", i), 32'(n_se - b_se), 32'(tbl[i].es));
            chk($sformatf("v%0d_glitch", i), 32'(n_g - b_g), 0);
            chk($sformatf("v%0d_data", i), 32'(data_out), 32'(tbl[i].ed));
            chk($sformatf("v%0d_busy", i), 32'(busy), 0);
            chk($sformatf("v%0d_latency", i), 32'(pulse_tick), 32'((1 + DW + int'(tbl[i].pe)) * p + p / 2 + 2));
        end

        // short low pulse on the line: start glitch at the end of the start bit
        prescale = 6'd8; par_en = 1'b0;
        snap();
        tick_no = 0;
        tick(1'b0); tick(1'b0); tick(1'b1);
        chk("glitch_busy_mid", 32'(busy), 1);
        repeat (5) tick(1'b1);
        chk("glitch_count", 32'(n_g - b_g), 1);
        chk("glitch_tick", 32'(pulse_tick), 8);
        chk("glitch_busy_after", 32'(busy), 0);
        chk("glitch_others", 32'((n_v - b_v) + (n_pe - b_pe) + (n_se - b_se)), 0);
        idle(2);

        // framing error followed by a long break
        prescale = 6'd16; par_en = 1'b0;
        build(16, 8'h81, 1'b0, 1'b0, 1'b0);
        snap();
        play(wave.size());
        repeat (40) tick(1'b0);
        chk("break_stop_err", 32'(n_se - b_se), 1);
        chk("break_busy", 32'(busy), 1);
        chk("break_no_restart", 32'((n_v - b_v) + (n_g - b_g) + (n_pe - b_pe)), 0);
        tick(1'b1);
        chk("break_release", 32'(busy), 0);
        idle(2);

        // noisy samples inside each data bit
        prescale = 6'd16; par_en = 1'b0;
        build(16, 8'h55, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_MAJORITY_VOTE_EN
        for (int k = 0; k < DW; k++) begin
            j = (1 + k) * 16 + 8 - 1 + k % 3;
            wave[j] = ~wave[j];
        end
        ed = 8'h55;
`else
        wave[16 + 8] = ~wave[16 + 8];
        ed = 8'h54;
`endif
        snap();
        play(wave.size());
        idle(3);
        chk("noise_valid", 32'(n_v - b_v), 1);
        chk("noise_data", 32'(data_out), 32'(ed));

        // reset in the middle of the data bits
        prescale = 6'd8; par_en = 1'b0;
        build(8, 8'hAA, 1'b0, 1'b0, 1'b1);
        snap();
        play(32);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        chk("abort_pulses", 32'((n_v - b_v) + (n_g - b_g) + (n_pe - b_pe) + (n_se - b_se)), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_data", 32'(data_out), 0);
        prescale = 6'd8;
        build(8, 8'h0F, 1'b0, 1'b0, 1'b1);
        snap();
        play(wave.size());
        idle(3);
        chk("after_abort_valid", 32'(n_v - b_v), 1);
        chk("after_abort_data", 32'(data_out), 32'h0F);

        // randomized frames against the waveform model
        m_data = 8'h0F;
        for (int f = 0; f < 30; f++) begin
            pre = $urandom_range(0, 24);
            p   = pre < 4 ? 4 : pre;
            d   = 8'($urandom);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            pb  = ($urandom_range(0, 3) == 0) ? ~(^d ^ pt) : (^d ^ pt);
            sb  = $urandom_range(0, 3) != 0;
            prescale = PW'(pre); par_en = pe; par_typ = pt;
            build(p, d, pe, pb, sb);
            for (int k = 1; k <= DW + int'(pe); k++)
                if ($urandom_range(0, 2) == 0) begin
                    j = k * p + p / 2 - 1 + int'($urandom_range(0, 2));
                    wave[j] = ~wave[j];
                end
            ed = '0;
            for (int k = 0; k < DW; k++) ed[k] = res(1 + k, p);
            ep = pe && (res(1 + DW, p) != (^ed ^ pt));
            es = res(1 + DW + int'(pe), p) != STOP_BIT;
            ev = !ep && !es;
            if (ev) m_data = ed;
            snap();
            play(wave.size());
            idle(3);
            chk($sformatf("r%0d_valid", f), 32'(n_v - b_v), 32'(ev));
            chk($sformatf("r%0d_par_err", f), 32'(n_pe - b_pe), 32'(ep));
            chk($sformatf("r%0d_stop_err", f), 32'(n_se - b_se), 32'(es));
            chk($sformatf("r%0d_data", f), 32'(data_out), 32'(m_data));
            chk($sformatf("r%0d_busy", f), 32'(busy), 0);
        end

        chk("pulse_width", 32'(width_err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
